// File: rtl/divider.sv
// Sequential restoring divider: a 2N-bit unsigned dividend divided by an
// N-bit unsigned divisor, one quotient bit per clock, MSB first.
// A zero divisor short-circuits straight to completion with saturated results.
module divider #(
    parameter int unsigned N = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           dbz
);

    localparam int unsigned DW = 2 * N;          // dividend / quotient width
    localparam int unsigned RW = N + 1;          // partial remainder width
    localparam int unsigned CW = $clog2(DW);     // iteration counter width
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Working registers: the dividend register shifts left and collects
    // quotient bits in its LSB, so it holds the full quotient after 2N steps.
    logic [DW-1:0] dvd_q, dvd_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Result registers, held between completions.
    logic [DW-1:0] quo_q, quo_d;
    logic [N-1:0]  rmd_q, rmd_d;
    logic          dbz_q, dbz_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Control strobes decoded from the FSM.
    logic accept_c;
    logic step_c;
    logic finish_c;
    logic zero_c;

    // One restoring step on the current working registers.
    logic [RW-1:0] rem_shift_c;
    logic [RW-1:0] rem_next_c;
    logic          qbit_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM output decode: datapath strobes and next values of busy/done.
    always_comb begin
        accept_c = 1'b0;
        step_c   = 1'b0;
        finish_c = 1'b0;
        zero_c   = 1'b0;
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        case (state_q)
            S_IDLE: begin
                accept_c = start;
                zero_c   = start && (divisor == '0);
            end
            S_RUN: begin
                step_c   = 1'b1;
                finish_c = (cnt_q == LAST);
            end
            default: begin
            end
        endcase
    end

    // Shift in the next dividend bit, compare against the divisor and
    // subtract when it fits; the extra remainder bit keeps the compare exact.
    always_comb begin
        rem_shift_c = RW'({rem_q, dvd_q[DW-1]});
        qbit_c      = (rem_shift_c >= {1'b0, dvs_q});
        rem_next_c  = qbit_c ? (rem_shift_c - {1'b0, dvs_q}) : rem_shift_c;
    end

    // Datapath next-state: operand capture, iteration and result update.
    always_comb begin
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        quo_d = quo_q;
        rmd_d = rmd_q;
        dbz_d = dbz_q;
        if (accept_c) begin
            dvd_d = dividend;
            dvs_d = divisor;
            rem_d = '0;
            cnt_d = '0;
            if (zero_c) begin
                quo_d = '1;
                rmd_d = '0;
                dbz_d = 1'b1;
            end
        end else if (step_c) begin
            dvd_d = {dvd_q[DW-2:0], qbit_c};
            rem_d = rem_next_c;
            cnt_d = cnt_q + CW'(1);
            if (finish_c) begin
                quo_d = {dvd_q[DW-2:0], qbit_c};
                rmd_d = rem_next_c[N-1:0];
                dbz_d = 1'b0;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rmd_q  <= '0;
            dbz_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rmd_q  <= rmd_d;
            dbz_q  <= dbz_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rmd_q;
    assign dbz       = dbz_q;

endmodule
